// File: rtl/lut2_sweep_pkg.sv
// Shared types and helpers for the LUT2 bank sweep controller.
// Address and expected-bit rules are kept here so the pattern generator and any bench model agree.
package lut2_sweep_pkg;

    localparam int LUT_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Address seen by LUT k during vector j: (j + k) mod 4.
    function automatic logic [1:0] addr_of(input logic [1:0] j, input int k);
        logic [31:0] k_v;
        k_v = k;
        return j + k_v[1:0];
    endfunction

    // Expected output of LUT k (INIT = k mod 16) at address a.
    function automatic logic exp_bit(input int k, input logic [1:0] a);
        logic [31:0] k_v;
        logic [3:0]  init_v;
        k_v    = k;
        init_v = k_v[3:0];
        return init_v[a];
    endfunction

endpackage

// File: rtl/lut2_sweep_pattern.sv
// Maps a vector index to the packed bank input pattern and the expected bank output word.
module lut2_sweep_pattern
    import lut2_sweep_pkg::*;
#(
    parameter int N_LUT = 16
) (
    input  logic [1:0]         i_vec,
    output logic [2*N_LUT-1:0] o_pattern,
    output logic [N_LUT-1:0]   o_expected
);

    // Per-LUT address ({I1,I0}) and the INIT bit that address selects.
    always_comb begin
        o_pattern  = '0;
        o_expected = '0;
        for (int k = 0; k < N_LUT; k++) begin
            o_pattern[2*k +: 2] = addr_of(i_vec, k);
            o_expected[k]       = exp_bit(k, addr_of(i_vec, k));
        end
    end

endmodule

// File: rtl/lut2_sweep_ctrl.sv
// Sweeps a bank of LUT2 primitives through all four addresses and checks the outputs
// against each LUT's INIT, reporting a saturating mismatch count and the first failure.
module lut2_sweep_ctrl
    import lut2_sweep_pkg::*;
#(
    parameter int N_LUT  = 16,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [2*N_LUT-1:0]   lut_i,
    input  logic [N_LUT-1:0]     lut_o,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 fail_valid,
    output logic [LUT_IDX_W-1:0] fail_lut,
    output logic [1:0]           fail_vec
);

    localparam int         POP_W     = $clog2(N_LUT + 1);
    localparam int         SUM_W     = CNT_W + POP_W;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_vec,        w_vec_nxt;
    logic [3:0]             r_settle,     w_settle_nxt;
    logic [2*N_LUT-1:0]     r_lut_i,      w_lut_i_nxt;
    logic [N_LUT-1:0]       r_exp,        w_exp_nxt;
    logic                   r_busy,       w_busy_nxt;
    logic                   r_done,       w_done_nxt;
    logic                   r_pass,       w_pass_nxt;
    logic [CNT_W-1:0]       r_err_cnt,    w_err_cnt_nxt;
    logic                   r_fail_valid, w_fail_valid_nxt;
    logic [LUT_IDX_W-1:0]   r_fail_lut,   w_fail_lut_nxt;
    logic [1:0]             r_fail_vec,   w_fail_vec_nxt;

    logic [1:0]             w_pat_vec;
    logic [2*N_LUT-1:0]     w_pattern;
    logic [N_LUT-1:0]       w_expected;
    logic [N_LUT-1:0]       w_mism;
    logic [POP_W-1:0]       w_pop;
    logic [LUT_IDX_W-1:0]   w_first;
    logic [SUM_W-1:0]       w_sum;
    logic [CNT_W-1:0]       w_err_sat;

    // The pattern is only ever loaded for vector 0 (from IDLE) or the next vector (from CHECK);
    // the expected word is registered alongside it so CHECK compares against the held vector.
    assign w_pat_vec = (r_state == CHECK) ? (r_vec + 2'd1) : 2'd0;

    lut2_sweep_pattern #(
        .N_LUT (N_LUT)
    ) u_pattern (
        .i_vec      (w_pat_vec),
        .o_pattern  (w_pattern),
        .o_expected (w_expected)
    );

    // Mismatch popcount and lowest failing LUT index.
    always_comb begin
        w_mism  = lut_o ^ r_exp;
        w_pop   = '0;
        w_first = '0;
        for (int k = N_LUT - 1; k >= 0; k--) begin
            w_pop   = w_pop + POP_W'(w_mism[k]);
            w_first = w_mism[k] ? LUT_IDX_W'(k) : w_first;
        end
        w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_pop);
        w_err_sat = (w_sum[SUM_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort takes priority everywhere, including over start in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !abort) w_state_nxt = HOLD;
                else                 w_state_nxt = IDLE;
            end
            HOLD: begin
                if (abort)                 w_state_nxt = IDLE;
                else if (r_settle == 4'd0) w_state_nxt = CHECK;
                else                       w_state_nxt = HOLD;
            end
            CHECK: begin
                if (abort)               w_state_nxt = IDLE;
                else if (r_vec == 2'd3)  w_state_nxt = FIN;
                else                     w_state_nxt = HOLD;
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values for the datapath and status registers.
    always_comb begin
        w_vec_nxt        = r_vec;
        w_settle_nxt     = r_settle;
        w_lut_i_nxt      = r_lut_i;
        w_exp_nxt        = r_exp;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_pass_nxt       = r_pass;
        w_err_cnt_nxt    = r_err_cnt;
        w_fail_valid_nxt = r_fail_valid;
        w_fail_lut_nxt   = r_fail_lut;
        w_fail_vec_nxt   = r_fail_vec;
        if (abort && (r_state != IDLE)) begin
            w_busy_nxt  = 1'b0;
            w_lut_i_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        w_vec_nxt        = 2'd0;
                        w_settle_nxt     = SETTLE_LD;
                        w_lut_i_nxt      = w_pattern;
                        w_exp_nxt        = w_expected;
                        w_busy_nxt       = 1'b1;
                        w_pass_nxt       = 1'b0;
                        w_err_cnt_nxt    = '0;
                        w_fail_valid_nxt = 1'b0;
                        w_fail_lut_nxt   = '0;
                        w_fail_vec_nxt   = 2'd0;
                    end else begin
                        w_busy_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (r_settle != 4'd0) w_settle_nxt = r_settle - 4'd1;
                    else                  w_settle_nxt = r_settle;
                end
                CHECK: begin
                    w_err_cnt_nxt = w_err_sat;
                    if ((w_mism != '0) && !r_fail_valid) begin
                        w_fail_valid_nxt = 1'b1;
                        w_fail_lut_nxt   = w_first;
                        w_fail_vec_nxt   = r_vec;
                    end else begin
                        w_fail_valid_nxt = r_fail_valid;
                    end
                    if (r_vec != 2'd3) begin
                        w_vec_nxt    = r_vec + 2'd1;
                        w_settle_nxt = SETTLE_LD;
                        w_lut_i_nxt  = w_pattern;
                        w_exp_nxt    = w_expected;
                    end else begin
                        w_lut_i_nxt = '0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_sat == '0);
                    end
                end
                FIN: begin
                    w_busy_nxt = 1'b0;
                end
                default: begin
                    w_busy_nxt  = 1'b0;
                    w_lut_i_nxt = '0;
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= 2'd0;
            r_settle     <= 4'd0;
            r_lut_i      <= '0;
            r_exp        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_lut   <= '0;
            r_fail_vec   <= 2'd0;
        end else begin
            r_vec        <= w_vec_nxt;
            r_settle     <= w_settle_nxt;
            r_lut_i      <= w_lut_i_nxt;
            r_exp        <= w_exp_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_lut   <= w_fail_lut_nxt;
            r_fail_vec   <= w_fail_vec_nxt;
        end
    end

    assign lut_i      = r_lut_i;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_lut   = r_fail_lut;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_lut2_sweep_ctrl.sv
// Directed bench for lut2_sweep_ctrl with a behavioural 16-LUT bank model and a
// second CNT_W=4 instance on an all-zero bank to exercise counter saturation.
module tb_lut2_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] lut_i_s;
    logic [15:0] lut_o_s;
    logic        busy, done, pass, fail_valid;
    logic [7:0]  err_cnt;
    logic [5:0]  fail_lut;
    logic [1:0]  fail_vec;

    logic [31:0] sat_lut_i;
    logic [15:0] sat_lut_o = 16'h0000;
    logic        sat_busy, sat_done, sat_pass, sat_fail_valid;
    logic [3:0]  sat_err_cnt;
    logic [5:0]  sat_fail_lut;
    logic [1:0]  sat_fail_vec;

    int mode;          // 0 = good bank, 1 = LUT5 output stuck at 0, 2 = all outputs 0
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cyc, done_cnt, pat_bad, sweep_cyc;

    always #5 clk = ~clk;

    lut2_sweep_ctrl #(.N_LUT(16), .SETTLE(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lut_i(lut_i_s), .lut_o(lut_o_s),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_valid(fail_valid), .fail_lut(fail_lut), .fail_vec(fail_vec)
    );

    lut2_sweep_ctrl #(.N_LUT(16), .SETTLE(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lut_i(sat_lut_i), .lut_o(sat_lut_o),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_cnt(sat_err_cnt),
        .fail_valid(sat_fail_valid), .fail_lut(sat_fail_lut), .fail_vec(sat_fail_vec)
    );

    // Behavioural bank: LUT k has INIT = k, output = INIT[{I1,I0}].
    always_comb begin
        lut_o_s = '0;
        for (int k = 0; k < 16; k++) begin
            lut_o_s[k] = 1'((k >> lut_i_s[2*k +: 2]) & 1);
        end
        if (mode == 1)      lut_o_s[5] = 1'b0;
        else if (mode == 2) lut_o_s    = '0;
        else                lut_o_s    = lut_o_s;
    end

    function automatic logic [31:0] tb_pattern(input int j);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) begin
            p[2*k +: 2] = 2'((j + k) % 4);
        end
        return p;
    endfunction

    // Expected lut_i on busy cycle c: three cycles per vector, then 0 during FIN.
    function automatic logic [31:0] exp_lut_i(input int c);
        if (c < 12) return tb_pattern(c / 3);
        else        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep and follow it until busy drops, optionally pulsing start mid-sweep.
    task automatic run_sweep(input logic poke_start);
        busy_cyc = 0;
        done_cnt = 0;
        pat_bad  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep_cyc = 0;
        while (busy === 1'b1 && sweep_cyc < 40) begin
            busy_cyc++;
            if (done === 1'b1) done_cnt++;
            if (lut_i_s !== exp_lut_i(sweep_cyc)) pat_bad++;
            start = (poke_start && sweep_cyc == 4);
            tick();
            sweep_cyc++;
        end
        start = 1'b0;
        check("sweep_in_bound", 64'(sweep_cyc < 40), 64'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (2) tick();
        check("rst_lut_i",      64'(lut_i_s),    64'h0);
        check("rst_busy",       64'(busy),       64'h0);
        check("rst_done",       64'(done),       64'h0);
        check("rst_pass",       64'(pass),       64'h0);
        check("rst_err_cnt",    64'(err_cnt),    64'h0);
        check("rst_fail_valid", 64'(fail_valid), 64'h0);
        check("rst_fail_lut",   64'(fail_lut),   64'h0);
        check("rst_fail_vec",   64'(fail_vec),   64'h0);
        rst = 1'b0;
        tick();

        // Good bank, with a start pulse mid-sweep that must be ignored.
        mode = 0;
        start = 1'b1;
        tick();
        check("first_pattern_low_nibble", 64'(lut_i_s[3:0]), 64'h4);
        start = 1'b0;
        repeat (20) tick();
        run_sweep(1'b1);
        check("good_busy_cycles", 64'(busy_cyc),   64'd13);
        check("good_done_once",   64'(done_cnt),   64'd1);
        check("good_pattern_seq", 64'(pat_bad),    64'd0);
        check("good_pass",        64'(pass),       64'd1);
        check("good_err_cnt",     64'(err_cnt),    64'd0);
        check("good_fail_valid",  64'(fail_valid), 64'd0);
        check("good_lut_i_idle",  64'(lut_i_s),    64'h0);
        check("sat_err_cnt",      64'(sat_err_cnt), 64'd15);
        check("sat_pass",         64'(sat_pass),    64'd0);

        // LUT5 output stuck at 0: mismatches at address 0 (j=3) and address 2 (j=1).
        mode = 1;
        run_sweep(1'b0);
        check("stuck_done_once",  64'(done_cnt),   64'd1);
        check("stuck_err_cnt",    64'(err_cnt),    64'd2);
        check("stuck_fail_valid", 64'(fail_valid), 64'd1);
        check("stuck_fail_lut",   64'(fail_lut),   64'd5);
        check("stuck_fail_vec",   64'(fail_vec),   64'd1);
        check("stuck_pass",       64'(pass),       64'd0);

        // All-zero bank: 32 expected ones, first at LUT6 in vector 0.
        mode = 2;
        run_sweep(1'b0);
        check("zero_err_cnt",  64'(err_cnt),  64'd32);
        check("zero_fail_lut", 64'(fail_lut), 64'd6);
        check("zero_fail_vec", 64'(fail_vec), 64'd0);
        check("zero_pass",     64'(pass),     64'd0);

        // abort together with start in IDLE: the sweep must not begin.
        mode  = 0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy",  64'(busy),    64'd0);
        check("abort_start_lut_i", 64'(lut_i_s), 64'h0);

        // abort in the second HOLD window.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("second_hold_pattern", 64'(lut_i_s), 64'(tb_pattern(1)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  64'(busy),    64'd0);
        check("abort_lut_i", 64'(lut_i_s), 64'h0);
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_pass_kept_clear", 64'(pass), 64'd0);
        run_sweep(1'b0);
        check("rerun_done_once", 64'(done_cnt), 64'd1);
        check("rerun_pass",      64'(pass),     64'd1);

        // Asynchronous reset during the second CHECK cycle.
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_rst_err_nonzero", 64'(err_cnt != 8'd0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy",       64'(busy),       64'd0);
        check("async_rst_lut_i",      64'(lut_i_s),    64'h0);
        check("async_rst_err_cnt",    64'(err_cnt),    64'd0);
        check("async_rst_fail_valid", 64'(fail_valid), 64'd0);
        check("async_rst_done",       64'(done),       64'd0);
        tick();
        rst  = 1'b0;
        mode = 0;
        tick();
        run_sweep(1'b0);
        check("post_rst_busy_cycles", 64'(busy_cyc), 64'd13);
        check("post_rst_done_once",   64'(done_cnt), 64'd1);
        check("post_rst_pass",        64'(pass),     64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
